// File: rtl/auth_pkg.sv
// Shared types and default command bytes for the rider-authentication controller.
package auth_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        ON       = 2'b01,
        STOPPING = 2'b10
    } auth_state_t;

    typedef enum logic [1:0] {
        NONE    = 2'b00,
        CMD     = 2'b01,
        TIMEOUT = 2'b10
    } stop_reason_t;

    localparam logic [7:0] GO_CMD_DEF   = 8'h47;
    localparam logic [7:0] STOP_CMD_DEF = 8'h53;
    localparam logic [7:0] HB_CMD_DEF   = 8'h48;

endpackage

// File: rtl/auth_ctrl_if.sv
// App-link and power-path signals of auth_ctrl; slave is the controller, master the platform side.
interface auth_ctrl_if;
    import auth_pkg::*;

    logic         rx;
    logic         rider_off;
    logic         pwr_up;
    logic         link_ok;
    stop_reason_t stop_reason;
    logic         cmd_err;

    modport slave (
        input  rx,
        input  rider_off,
        output pwr_up,
        output link_ok,
        output stop_reason,
        output cmd_err
    );

    modport master (
        output rx,
        output rider_off,
        input  pwr_up,
        input  link_ok,
        input  stop_reason,
        input  cmd_err
    );

endinterface

// File: rtl/auth_timer.sv
// Saturating up-counter with synchronous clear; done is registered and high while count == TERM-1.
// Latency: done reflects the count after the same edge that updates it; no backpressure.
module auth_timer #(
    parameter int TERM = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic done
);

    localparam int              W      = (TERM < 2) ? 1 : $clog2(TERM + 1);
    localparam int              LAST_I = (TERM > 0) ? TERM - 1 : 0;
    localparam logic [W-1:0]    LAST   = W'(LAST_I);

    logic [W-1:0] r_cnt;
    logic [W-1:0] w_nxt;
    logic         r_done;

    always_comb begin
        w_nxt = r_cnt;
        if (clr) begin
            w_nxt = '0;
        end else if (en && (r_cnt != LAST)) begin
            w_nxt = r_cnt + 1'b1;
        end
    end

    // A terminal value of 0 means done is already true straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_done <= (LAST_I == 0);
        end else begin
            r_cnt  <= w_nxt;
            r_done <= (w_nxt == LAST);
        end
    end

    assign done = r_done;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, rdy held until clr_rdy or next start bit.
// Latency: rdy rises at the mid-stop-bit sample edge; no backpressure, an unread byte is overwritten.
module UART_rx #(
    parameter int BAUD_CYC = 2604
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy
);

    localparam int           BW          = (BAUD_CYC < 2) ? 1 : $clog2(BAUD_CYC);
    localparam logic [BW-1:0] BAUD_RELOAD = BW'(BAUD_CYC - 1);
    localparam logic [BW-1:0] BAUD_HALF   = BW'(BAUD_CYC / 2);

    logic          r_rx_ff1;
    logic          r_rx_ff2;
    logic          r_busy;
    logic          r_rdy;
    logic [BW-1:0] r_baud_cnt;
    logic [3:0]    r_bit_cnt;
    logic [8:0]    r_shift;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_ff1   <= 1'b1;
            r_rx_ff2   <= 1'b1;
            r_busy     <= 1'b0;
            r_rdy      <= 1'b0;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
        end else begin
            r_rx_ff1 <= RX;
            r_rx_ff2 <= r_rx_ff1;
            if (clr_rdy) begin
                r_rdy <= 1'b0;
            end
            if (!r_busy) begin
                if (!r_rx_ff2) begin
                    r_busy     <= 1'b1;
                    r_baud_cnt <= BAUD_HALF;
                    r_bit_cnt  <= '0;
                    r_rdy      <= 1'b0;
                end
            end else if (r_baud_cnt != '0) begin
                r_baud_cnt <= r_baud_cnt - 1'b1;
            end else begin
                // Ten samples: start, eight data, stop; the start bit falls out of the 9-bit shifter.
                r_shift    <= {r_rx_ff2, r_shift[8:1]};
                r_baud_cnt <= BAUD_RELOAD;
                r_bit_cnt  <= r_bit_cnt + 1'b1;
                if (r_bit_cnt == 4'd9) begin
                    r_busy <= 1'b0;
                    r_rdy  <= 1'b1;
                end
            end
        end
    end

    assign rx_data = r_shift[7:0];
    assign rdy     = r_rdy;

endmodule

// File: rtl/auth_ctrl.sv
// Gates pwr_up from app commands over UART with a link watchdog and rider_off debounce.
// Latency: a byte flagged at edge N changes state and outputs at edge N+1; no backpressure, bytes consumed at once.
module auth_ctrl
    import auth_pkg::*;
#(
    parameter logic [7:0] GO_CMD      = GO_CMD_DEF,
    parameter logic [7:0] STOP_CMD    = STOP_CMD_DEF,
    parameter logic [7:0] HB_CMD      = HB_CMD_DEF,
    parameter int         TIMEOUT_CYC = 50_000_000,
    parameter int         DEB_CYC     = 1024,
    parameter int         BAUD_CYC    = 2604
) (
    input  logic          clk,
    input  logic          rst_n,
    auth_ctrl_if.slave    bus
);

    localparam bit WD_EN = (TIMEOUT_CYC > 0);

    logic [7:0]   w_rx_data;
    logic         w_rdy;
    logic         w_go;
    logic         w_stop;
    logic         w_hb;
    logic         w_valid;
    logic         w_wd_done;
    logic         w_wd_fire;
    logic         w_wd_clr;
    logic         w_deb_done;
    logic         w_deb_fire;
    logic         w_deb_clr;

    auth_state_t  r_state;
    logic         r_pwr_up;
    logic         r_link_ok;
    stop_reason_t r_stop_reason;
    logic         r_cmd_err;

    // rdy doubles as its own clear so every byte lives for exactly one cycle.
    UART_rx #(
        .BAUD_CYC (BAUD_CYC)
    ) u_uart_rx (
        .clk     (clk),
        .rst_n   (rst_n),
        .RX      (bus.rx),
        .clr_rdy (w_rdy),
        .rx_data (w_rx_data),
        .rdy     (w_rdy)
    );

    assign w_go    = w_rdy && (w_rx_data == GO_CMD);
    assign w_stop  = w_rdy && (w_rx_data == STOP_CMD);
    assign w_hb    = w_rdy && (w_rx_data == HB_CMD);
    assign w_valid = w_go || w_stop || w_hb;

    // Any valid byte in ON outranks a coincident watchdog expiry.
    assign w_wd_fire = WD_EN && w_wd_done && !w_valid;
    assign w_wd_clr  = (r_state != ON) || w_valid || w_wd_fire;

    assign w_deb_fire = w_deb_done && bus.rider_off;
    assign w_deb_clr  = (r_state != STOPPING) || !bus.rider_off || w_go || w_deb_fire;

    auth_timer #(
        .TERM (TIMEOUT_CYC)
    ) u_wd_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_wd_clr),
        .en    (r_state == ON),
        .done  (w_wd_done)
    );

    auth_timer #(
        .TERM (DEB_CYC)
    ) u_deb_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_deb_clr),
        .en    (r_state == STOPPING),
        .done  (w_deb_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_pwr_up      <= 1'b0;
            r_link_ok     <= 1'b0;
            r_stop_reason <= NONE;
            r_cmd_err     <= 1'b0;
        end else begin
            r_cmd_err <= w_rdy && !w_valid;
            case (r_state)
                IDLE: begin
                    r_stop_reason <= NONE;
                    if (w_go) begin
                        r_state   <= ON;
                        r_pwr_up  <= 1'b1;
                        r_link_ok <= 1'b1;
                    end
                end
                ON: begin
                    if (w_stop) begin
                        r_state       <= STOPPING;
                        r_link_ok     <= 1'b0;
                        r_stop_reason <= CMD;
                    end else if (w_wd_fire) begin
                        r_state       <= STOPPING;
                        r_link_ok     <= 1'b0;
                        r_stop_reason <= TIMEOUT;
                    end
                end
                STOPPING: begin
                    if (w_go) begin
                        r_state       <= ON;
                        r_link_ok     <= 1'b1;
                        r_stop_reason <= NONE;
                    end else if (w_deb_fire) begin
                        r_state       <= IDLE;
                        r_pwr_up      <= 1'b0;
                        r_link_ok     <= 1'b0;
                        r_stop_reason <= NONE;
                    end
                end
                default: begin
                    r_state       <= IDLE;
                    r_pwr_up      <= 1'b0;
                    r_link_ok     <= 1'b0;
                    r_stop_reason <= NONE;
                end
            endcase
        end
    end

    assign bus.pwr_up      = r_pwr_up;
    assign bus.link_ok     = r_link_ok;
    assign bus.stop_reason = r_stop_reason;
    assign bus.cmd_err     = r_cmd_err;

endmodule

// File: tb/tb_auth_ctrl.sv
// Directed bench for auth_ctrl with TIMEOUT_CYC=1000, DEB_CYC=8 and a 16-cycle UART bit time.
module tb_auth_ctrl;

    localparam int BIT = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_err_pulses = 0;
    int   c0;

    auth_ctrl_if bus ();

    auth_ctrl #(
        .TIMEOUT_CYC (1000),
        .DEB_CYC     (8),
        .BAUD_CYC    (BIT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.cmd_err === 1'b1) n_err_pulses++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called on a negedge; returns on the negedge where the stop bit starts (144 cycles later).
    task automatic send_head(input logic [7:0] b);
        bus.rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            repeat (BIT) @(negedge clk);
        end
        bus.rx = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_head(b);
        repeat (BIT) @(negedge clk);
    endtask

    initial begin
        bus.rx        = 1'b1;
        bus.rider_off = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pwr_up", bus.pwr_up, 0);
        chk("rst_link_ok", bus.link_ok, 0);
        chk("rst_reason", bus.stop_reason, 0);
        chk("rst_cmd_err", bus.cmd_err, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // 'S' and an unknown byte in IDLE.
        c0 = n_err_pulses;
        send_byte(8'h53);
        chk("idle_S_pwr", bus.pwr_up, 0);
        chk("idle_S_reason", bus.stop_reason, 0);
        send_head(8'h58);
        repeat (12) @(negedge clk);
        chk("X_err_before", bus.cmd_err, 0);
        @(negedge clk);
        chk("X_err_pulse", bus.cmd_err, 1);
        @(negedge clk);
        chk("X_err_after", bus.cmd_err, 0);
        repeat (2) @(negedge clk);
        chk("X_err_once", n_err_pulses - c0, 1);
        chk("idle_X_pwr", bus.pwr_up, 0);

        // GO: outputs change one cycle after rdy.
        send_head(8'h47);
        repeat (12) @(negedge clk);
        chk("go_pwr_before", bus.pwr_up, 0);
        @(negedge clk);
        chk("go_pwr", bus.pwr_up, 1);
        chk("go_link", bus.link_ok, 1);
        chk("go_reason", bus.stop_reason, 0);
        repeat (3) @(negedge clk);

        // Heartbeats every 900 cycles keep the link alive.
        for (int i = 0; i < 6; i++) begin
            send_head(8'h48);
            repeat (BIT) @(negedge clk);
            chk("hb_link_mid", bus.link_ok, 1);
            repeat (740) @(negedge clk);
            chk("hb_link_end", bus.link_ok, 1);
        end

        // Last heartbeat, then silence: STOPPING exactly 1000 cycles after it is consumed.
        send_head(8'h48);
        repeat (13) @(negedge clk);
        repeat (999) @(negedge clk);
        chk("wd_link_before", bus.link_ok, 1);
        @(negedge clk);
        chk("wd_link", bus.link_ok, 0);
        chk("wd_reason", bus.stop_reason, 2);
        chk("wd_pwr", bus.pwr_up, 1);

        // Debounce: 7 high, 1 low, then 8 high.
        bus.rider_off = 1'b1;
        repeat (7) @(negedge clk);
        bus.rider_off = 1'b0;
        chk("deb_run7_pwr", bus.pwr_up, 1);
        @(negedge clk);
        bus.rider_off = 1'b1;
        repeat (7) @(negedge clk);
        chk("deb_pre_pwr", bus.pwr_up, 1);
        chk("deb_pre_reason", bus.stop_reason, 2);
        @(negedge clk);
        chk("deb_idle_pwr", bus.pwr_up, 0);
        chk("deb_idle_link", bus.link_ok, 0);
        chk("deb_idle_reason", bus.stop_reason, 0);
        bus.rider_off = 1'b0;

        // STOP command, then GO coincident with the 8th rider_off sample.
        send_byte(8'h47);
        send_byte(8'h53);
        chk("stop_link", bus.link_ok, 0);
        chk("stop_reason", bus.stop_reason, 1);
        chk("stop_pwr", bus.pwr_up, 1);
        send_head(8'h47);
        repeat (5) @(negedge clk);
        bus.rider_off = 1'b1;
        repeat (7) @(negedge clk);
        chk("coin_link_before", bus.link_ok, 0);
        @(negedge clk);
        chk("coin_link", bus.link_ok, 1);
        chk("coin_pwr", bus.pwr_up, 1);
        chk("coin_reason", bus.stop_reason, 0);
        bus.rider_off = 1'b0;
        repeat (3) @(negedge clk);

        // Reset mid-byte in ON drops power asynchronously.
        bus.rx = 1'b0;
        repeat (40) @(negedge clk);
        chk("mid_pwr", bus.pwr_up, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_pwr", bus.pwr_up, 0);
        chk("rst_async_link", bus.link_ok, 0);
        bus.rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_rst_pwr", bus.pwr_up, 0);
        send_byte(8'h48);
        repeat (2) @(negedge clk);
        chk("post_rst_hb_pwr", bus.pwr_up, 0);
        send_head(8'h47);
        repeat (13) @(negedge clk);
        chk("post_rst_go_pwr", bus.pwr_up, 1);
        chk("post_rst_go_link", bus.link_ok, 1);
        repeat (3) @(negedge clk);
        chk("cmd_err_total", n_err_pulses - c0, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/auth_ctrl.md
# auth_ctrl

Parametrised rider-authentication controller for the Segway power path. It receives command bytes from the phone app over UART and gates `pwr_up` to the balance and motor logic. Command codes are configurable, a heartbeat/link-loss watchdog turns a silent link into a stop request, and `rider_off` is debounced before the platform is allowed to power down.

## Interface
- `GO_CMD`, default 8'h47 ('G'): power-up / resume command byte.
- `STOP_CMD`, default 8'h53 ('S'): stop request byte.
- `HB_CMD`, default 8'h48 ('H'): heartbeat byte; it refreshes the watchdog only.
- `TIMEOUT_CYC`, default 50_000_000: clk cycles without a valid byte in ON before a link-loss stop; 0 disables the watchdog.
- `DEB_CYC`, default 1024: consecutive cycles `rider_off` must be high in STOPPING before power-down; minimum 1.
- `clk`, input, 1: system clock.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `rx`, input, 1: UART serial input from the BLE module.
- `rider_off`, input, 1: high when platform weight is below MIN_RIDER_WEIGHT.
- `pwr_up`, output, 1: enables the balance controller and motor drive.
- `link_ok`, output, 1: high only in ON.
- `stop_reason`, output, 2: 2'b00 none, 2'b01 STOP command, 2'b10 watchdog timeout.
- `cmd_err`, output, 1: one-cycle pulse when a received byte matches none of the three commands.

## Operation
- An internal UART_rx deserialises bytes. Its `clr_rdy` equals `rdy`, so every byte is consumed in the cycle it is flagged, in every state.
- `valid_byte` is true when `rdy` is high and the byte equals GO_CMD, STOP_CMD or HB_CMD. If `rdy` is high and the byte matches none of them, `cmd_err` pulses on the next cycle. Command values must be distinct.
- States: IDLE, ON, STOPPING. Any illegal encoding returns to IDLE.
- **IDLE:** GO moves to ON and clears the watchdog. All other bytes are ignored, and `stop_reason` holds 00.
- **ON:**
  - GO or HB clears the watchdog.
  - STOP moves to STOPPING with `stop_reason`=01.
  - A watchdog count reaching TIMEOUT_CYC-1 with no valid byte moves to STOPPING with `stop_reason`=10.
  - If a byte and watchdog expiry occur in the same cycle, the byte wins.
- **STOPPING:**
  - GO returns to ON, clears `stop_reason` to 00 and clears the watchdog.
  - The debounce counter increments while `rider_off`=1 and clears whenever `rider_off`=0.
  - When the count reaches DEB_CYC-1 with `rider_off` still 1, the block moves to IDLE.
  - If GO arrives in the same cycle as debounce completion, GO wins.
  - STOP and HB are ignored.
- Entering IDLE clears `stop_reason` and both counters.
- `pwr_up` is high in ON and STOPPING.
- Counter widths are $clog2(TIMEOUT_CYC+1) and $clog2(DEB_CYC+1). Counters never wrap: each is cleared on every state transition and saturates at its terminal value.

## Timing
- Reset values: state IDLE, `pwr_up`=0, `link_ok`=0, `stop_reason`=00, `cmd_err`=0, counters 0. UART_rx is reset from the same `rst_n`.
- All outputs are registered and decoded from the state register. No combinational path runs from `rx` or `rider_off` to any output.
- Latency: a byte flagged at edge N changes state at edge N+1, so outputs change after edge N+1.
- Watchdog: a link with no valid bytes in ON stops exactly TIMEOUT_CYC cycles after the last valid byte or ON entry.
- Debounce: exactly DEB_CYC consecutive high samples of `rider_off` in STOPPING are required. A single low sample restarts the count.
- Asserting reset mid-operation (any state, including mid-byte on `rx`) immediately drops `pwr_up`. After release the block needs a fresh GO.

## Structure
- Package `auth_pkg` holds:
  - `auth_state_t` enum (IDLE, ON, STOPPING);
  - `stop_reason_t` enum (NONE=00, CMD=01, TIMEOUT=10);
  - default command constants GO_CMD_DEF, STOP_CMD_DEF, HB_CMD_DEF.
- Sub-module `auth_timer`: parametrised saturating up-counter (parameter TERM) with `clr`, `en` and a registered `done` flag at TERM-1. It is instantiated twice, once for the watchdog and once for debounce.
- The existing UART_rx is reused unchanged.

## Test plan
The bench uses TIMEOUT_CYC=1000, DEB_CYC=8 and default command bytes.
- Send 'S' then 'X' (8'h58) in IDLE -> `pwr_up` stays 0 and `cmd_err` pulses once, one cycle after the 'X' `rdy`.
- Send 'G' -> `pwr_up`=1 and `link_ok`=1 one cycle after `rdy`. Then send 'H' every 900 cycles for 5000 cycles -> the block stays in ON.
- In ON, send nothing -> STOPPING with `stop_reason`=10 exactly 1000 cycles after the last 'H'. `pwr_up` stays 1 and `link_ok`=0.
- In STOPPING, hold `rider_off` for 7 cycles, drop it 1 cycle, then hold it for 8 -> IDLE only after the second run of 8, `pwr_up`=0 and `stop_reason`=00.
- In STOPPING (`stop_reason`=01), deliver 'G' `rdy` in the same cycle as the 8th `rider_off` sample -> the block returns to ON, `pwr_up` stays 1 and `stop_reason`=00.
- Assert `rst_n` low mid-byte while in ON -> `pwr_up`=0 immediately. After release, a 'G' is needed to power up again.
